// File: rtl/rv32_mem_stage_if.sv
// Data-memory port of the rv32 memory stage: req/gnt handshake for the request
// phase, rvalid for load data return.
//   master : memory stage (drives request fields, receives gnt/rvalid/rdata)
//   slave  : data memory
interface rv32_mem_stage_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/rv32_mem_stage.sv
// rv32 memory stage: performs loads/stores for the instruction in exec_mem_buff
// over a req/gnt/rvalid port and registers the result into mem_wb_buff.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   exec_mem_buff  instruction from exec (mem_addr, wb_result = store data)
//   mem_wb_buff    registered writeback buffer (NOP bubble while stalled)
//   mem_stall      holds exec and earlier stages while an access is outstanding
//   wb_bypass      mem_wb_buff.wb_result, forwarded by exec
//   dmem           data-memory port (rv32_mem_stage_if.master)
//   misalign_fault 1-cycle pulse on misaligned half/word access
//                  (only with RV32_MEM_MISALIGN_TRAP_EN defined)
// Build option: RV32_MEM_MISALIGN_TRAP_EN traps misaligned accesses; without it
// the low address bits are forced to natural alignment.

package rv32_mem_pkg;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
   } mem_op_t;

   typedef struct packed {
      mem_op_t    mem_op;
      logic       reg_we;
      logic [4:0] rd;
   } decoded_instr_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    mem_addr;
      logic [31:0]    wb_result;
   } exec_mem_buffer_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    wb_result;
   } mem_wb_buffer_t;

   function automatic decoded_instr_t create_nop_ctrl();
      decoded_instr_t c;
      c.mem_op = MEM_NONE;
      c.reg_we = 1'b0;
      c.rd     = 5'd0;
      return c;
   endfunction

   function automatic mem_wb_buffer_t nop_wb_buff();
      mem_wb_buffer_t b;
      b.instr         = RV_NOP;
      b.pc            = 32'd0;
      b.decoded_instr = create_nop_ctrl();
      b.wb_result     = 32'd0;
      return b;
   endfunction
endpackage

module rv32_mem_stage
   import rv32_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  exec_mem_buffer_t        exec_mem_buff,
   output mem_wb_buffer_t          mem_wb_buff,
   output logic                    mem_stall,
   output logic [31:0]             wb_bypass,
`ifdef RV32_MEM_MISALIGN_TRAP_EN
   output logic                    misalign_fault,
`endif
   rv32_mem_stage_if.master        dmem
);

   typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_t;

   state_t           state_q, state_d;
   exec_mem_buffer_t hold_q, hold_d;
   mem_wb_buffer_t   mem_wb_q, mem_wb_d;
   logic             fault_q, fault_d;

   exec_mem_buffer_t cur;
   mem_op_t          op;
   logic             is_byte, is_half, is_word, is_load, is_store, is_mem;
   logic             misaligned;
   logic [1:0]       ofs;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      shifted;
   logic [31:0]      ld_data;
   logic             req;
   mem_wb_buffer_t   pass;

   // Outside IDLE the access is driven from the copy captured at issue, so the
   // request stays stable even if the upstream buffer changes.
   always_comb begin
      cur      = (state_q == StIdle) ? exec_mem_buff : hold_q;
      op       = cur.decoded_instr.mem_op;
      is_byte  = op inside {LB, LBU, SB};
      is_half  = op inside {LH, LHU, SH};
      is_word  = op inside {LW, SW};
      is_store = op inside {SB, SH, SW};
      is_load  = op inside {LB, LH, LW, LBU, LHU};
      is_mem   = is_load | is_store;
      ofs      = cur.mem_addr[1:0];
      misaligned = (is_half & ofs[0]) | (is_word & (ofs != 2'b00));
`ifndef RV32_MEM_MISALIGN_TRAP_EN
      if (is_half) ofs[0] = 1'b0;
      if (is_word) ofs    = 2'b00;
`endif

      be    = 4'b0000;
      wdata = cur.wb_result;
      if (is_byte) begin
         be    = 4'b0001 << ofs;
         wdata = {4{cur.wb_result[7:0]}};
      end else if (is_half) begin
         be    = ofs[1] ? 4'b1100 : 4'b0011;
         wdata = {2{cur.wb_result[15:0]}};
      end else if (is_word) begin
         be    = 4'b1111;
      end

      shifted = dmem.dmem_rdata >> {ofs, 3'b000};
      case (op)
         LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
         LBU:     ld_data = {24'd0, shifted[7:0]};
         LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
         LHU:     ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase

      pass.instr         = cur.instr;
      pass.pc            = cur.pc;
      pass.decoded_instr = cur.decoded_instr;
      pass.wb_result     = cur.wb_result;
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      mem_wb_d  = nop_wb_buff();
      req       = 1'b0;
      mem_stall = 1'b0;
      fault_d   = 1'b0;

      case (state_q)
         StIdle: begin
            hold_d = exec_mem_buff;
            if (!is_mem) begin
               mem_wb_d = pass;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
            end else if (misaligned) begin
               fault_d = 1'b1;
`endif
            end else begin
               req = 1'b1;
               if (is_store && dmem.dmem_gnt) begin
                  mem_wb_d = pass;
               end else begin
                  mem_stall = 1'b1;
                  state_d   = dmem.dmem_gnt ? StWaitRvalid : StWaitGnt;
               end
            end
         end
         StWaitGnt: begin
            req = 1'b1;
            // A granted store retires now; stalling would make exec re-present it.
            if (is_store && dmem.dmem_gnt) begin
               mem_wb_d = pass;
               state_d  = StIdle;
            end else begin
               mem_stall = 1'b1;
               if (dmem.dmem_gnt) state_d = StWaitRvalid;
            end
         end
         StWaitRvalid: begin
            if (dmem.dmem_rvalid) begin
               mem_wb_d           = pass;
               mem_wb_d.wb_result = ld_data;
               state_d            = StIdle;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         hold_q   <= '0;
         mem_wb_q <= nop_wb_buff();
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         mem_wb_q <= mem_wb_d;
         fault_q  <= fault_d;
      end
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = req & is_store;
   assign dmem.dmem_addr  = req ? {cur.mem_addr[ADDR_W-1:2], 2'b00} : '0;
   assign dmem.dmem_be    = req ? be : 4'b0000;
   assign dmem.dmem_wdata = req ? wdata : 32'd0;

   assign mem_wb_buff = mem_wb_q;
   assign wb_bypass   = mem_wb_q.wb_result;

`ifdef RV32_MEM_MISALIGN_TRAP_EN
   assign misalign_fault = fault_q;
`else
   logic unused_fault;
   assign unused_fault = fault_q ^ fault_d ^ misaligned;
`endif

endmodule

// File: tb/tb_rv32_mem_stage.sv
module tb_rv32_mem_stage;
   import rv32_mem_pkg::*;

   logic             clk = 1'b0;
   logic             resetn;
   exec_mem_buffer_t exec_mem_buff;
   mem_wb_buffer_t   mem_wb_buff;
   logic             mem_stall;
   logic [31:0]      wb_bypass;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
   logic             misalign_fault;
`endif

   int checks   = 0;
   int failures = 0;

   rv32_mem_stage_if #(.ADDR_W(32)) dmem_bus ();

   rv32_mem_stage #(.ADDR_W(32)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .exec_mem_buff (exec_mem_buff),
      .mem_wb_buff   (mem_wb_buff),
      .mem_stall     (mem_stall),
      .wb_bypass     (wb_bypass),
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      .misalign_fault(misalign_fault),
`endif
      .dmem          (dmem_bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exec_mem_buffer_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                           input mem_op_t op, input logic [31:0] addr,
                                           input logic [31:0] data);
      exec_mem_buffer_t e;
      e.instr                = instr;
      e.pc                   = pc;
      e.decoded_instr.mem_op = op;
      e.decoded_instr.reg_we = 1'b1;
      e.decoded_instr.rd     = 5'd1;
      e.mem_addr             = addr;
      e.wb_result            = data;
      return e;
   endfunction

   // Advance to 1 time unit after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      exec_mem_buff         = mk(RV_NOP, 32'd0, MEM_NONE, 32'd0, 32'd0);
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_rdata  = 32'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      #12;
      checks++; if (mem_wb_buff.instr !== RV_NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", mem_wb_buff.instr, RV_NOP); end
      checks++; if (mem_wb_buff.pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", mem_wb_buff.pc); end
      checks++; if (mem_wb_buff.decoded_instr !== create_nop_ctrl()) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", mem_wb_buff.decoded_instr, create_nop_ctrl()); end
      checks++; if (wb_bypass !== 32'd0) begin failures++; $display("FAIL reset_bypass got=%h exp=0", wb_bypass); end
      checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, mem_stall} !== 7'd0) begin failures++; $display("FAIL reset_bus req=%b we=%b be=%b stall=%b exp all 0", dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, mem_stall); end
      @(negedge clk);
      resetn = 1'b1;
      cycle();
   endtask

   task automatic test_alu();
      exec_mem_buff = mk(32'h00a00093, 32'h40, MEM_NONE, 32'd0, 32'h1234);
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL alu_req req=%b stall=%b exp 0 0", dmem_bus.dmem_req, mem_stall); end
      cycle();
      idle_inputs();
      checks++; if (mem_wb_buff.wb_result !== 32'h1234) begin failures++; $display("FAIL alu_result got=%h exp=1234", mem_wb_buff.wb_result); end
      checks++; if (wb_bypass !== 32'h1234) begin failures++; $display("FAIL alu_bypass got=%h exp=1234", wb_bypass); end
      checks++; if (mem_wb_buff.pc !== 32'h40 || mem_wb_buff.instr !== 32'h00a00093) begin failures++; $display("FAIL alu_fields pc=%h instr=%h exp 40 00a00093", mem_wb_buff.pc, mem_wb_buff.instr); end
   endtask

   task automatic test_sb();
      exec_mem_buff = mk(32'h0ab101a3, 32'h44, SB, 32'h103, 32'h0000_00ab);
      dmem_bus.dmem_gnt = 1'b1;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1) begin failures++; $display("FAIL sb_req req=%b we=%b exp 1 1", dmem_bus.dmem_req, dmem_bus.dmem_we); end
      checks++; if (dmem_bus.dmem_addr !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=100", dmem_bus.dmem_addr); end
      checks++; if (dmem_bus.dmem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", dmem_bus.dmem_be); end
      checks++; if (dmem_bus.dmem_wdata !== 32'habababab) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_bus.dmem_wdata); end
      checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL sb_stall got=%b exp=0", mem_stall); end
      cycle();
      idle_inputs();
      #1;
      checks++; if (mem_wb_buff.instr !== 32'h0ab101a3) begin failures++; $display("FAIL sb_wb got=%h exp=0ab101a3", mem_wb_buff.instr); end
      checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL sb_after stall=%b req=%b exp 0 0", mem_stall, dmem_bus.dmem_req); end
      cycle();
   endtask

   // gnt in cycle 2, rvalid in cycle 5; stray rvalid in cycle 1 (WAIT_GNT) is ignored.
   task automatic test_lb_waits();
      int bubbles = 0;
      exec_mem_buff = mk(32'h00100083, 32'h80, LB, 32'h101, 32'd0);
      for (int c = 0; c < 6; c++) begin
         // Upstream address disturbed while waiting: request must come from the held copy.
         if (c == 1) exec_mem_buff.mem_addr = 32'h3ff;
         dmem_bus.dmem_gnt    = (c == 2);
         dmem_bus.dmem_rvalid = (c == 1) || (c == 5);
         dmem_bus.dmem_rdata  = (c == 5) ? 32'h0000_8000 : 32'hdead_beef;
         #1;
         checks++; if (mem_stall !== (c < 5)) begin failures++; $display("FAIL lb_stall c=%0d got=%b exp=%b", c, mem_stall, (c < 5)); end
         checks++; if (dmem_bus.dmem_req !== (c <= 2)) begin failures++; $display("FAIL lb_req c=%0d got=%b exp=%b", c, dmem_bus.dmem_req, (c <= 2)); end
         if (c <= 2) begin
            checks++; if (dmem_bus.dmem_addr !== 32'h100 || dmem_bus.dmem_be !== 4'b0010 || dmem_bus.dmem_we !== 1'b0) begin failures++; $display("FAIL lb_fields c=%0d addr=%h be=%b we=%b exp 100 0010 0", c, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_we); end
         end
         if (c >= 1 && mem_wb_buff.instr === RV_NOP && mem_wb_buff.decoded_instr === create_nop_ctrl()) bubbles++;
         cycle();
      end
      idle_inputs();
      checks++; if (bubbles != 5) begin failures++; $display("FAIL lb_bubbles got=%0d exp=5", bubbles); end
      checks++; if (mem_wb_buff.instr !== 32'h00100083 || mem_wb_buff.wb_result !== 32'hffffff80) begin failures++; $display("FAIL lb_result instr=%h data=%h exp 00100083 ffffff80", mem_wb_buff.instr, mem_wb_buff.wb_result); end
      cycle();
      checks++; if (mem_wb_buff.instr !== RV_NOP) begin failures++; $display("FAIL lb_once got=%h exp=%h", mem_wb_buff.instr, RV_NOP); end
   endtask

   // LHU (gnt + stray rvalid on issue), then SW issued the cycle after rvalid.
   task automatic test_back_to_back();
      exec_mem_buff = mk(32'h00215083, 32'h90, LHU, 32'h102, 32'd0);
      dmem_bus.dmem_gnt    = 1'b1;
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'h1234_5678;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_be !== 4'b1100 || mem_stall !== 1'b1) begin failures++; $display("FAIL lhu_issue req=%b be=%b stall=%b exp 1 1100 1", dmem_bus.dmem_req, dmem_bus.dmem_be, mem_stall); end
      cycle();
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'hbeef_0000;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL lhu_rvalid req=%b stall=%b exp 0 0", dmem_bus.dmem_req, mem_stall); end
      cycle();
      checks++; if (mem_wb_buff.wb_result !== 32'h0000beef) begin failures++; $display("FAIL lhu_result got=%h exp=0000beef", mem_wb_buff.wb_result); end
      exec_mem_buff        = mk(32'h00112023, 32'h94, SW, 32'h200, 32'hcafe_f00d);
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_gnt    = 1'b1;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1 || dmem_bus.dmem_be !== 4'b1111) begin failures++; $display("FAIL sw_req req=%b we=%b be=%b exp 1 1 1111", dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be); end
      checks++; if (dmem_bus.dmem_addr !== 32'h200 || dmem_bus.dmem_wdata !== 32'hcafef00d || mem_stall !== 1'b0) begin failures++; $display("FAIL sw_fields addr=%h wdata=%h stall=%b exp 200 cafef00d 0", dmem_bus.dmem_addr, dmem_bus.dmem_wdata, mem_stall); end
      cycle();
      idle_inputs();
      checks++; if (mem_wb_buff.instr !== 32'h00112023) begin failures++; $display("FAIL sw_wb got=%h exp=00112023", mem_wb_buff.instr); end
      cycle();
   endtask

   task automatic test_reset_mid();
      exec_mem_buff     = mk(32'h00302083, 32'ha0, LW, 32'h300, 32'd0);
      dmem_bus.dmem_gnt = 1'b1;
      cycle();
      dmem_bus.dmem_gnt = 1'b0;
      #1;
      checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall got=%b exp=1", mem_stall); end
      resetn               = 1'b0;
      exec_mem_buff        = mk(RV_NOP, 32'd0, MEM_NONE, 32'd0, 32'd0);
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'h0000_0055;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wb_buff.instr !== RV_NOP) begin failures++; $display("FAIL rst_mid req=%b stall=%b instr=%h exp 0 0 %h", dmem_bus.dmem_req, mem_stall, mem_wb_buff.instr, RV_NOP); end
      cycle();
      resetn = 1'b1;
      cycle();
      checks++; if (mem_wb_buff.instr !== RV_NOP || mem_wb_buff.wb_result !== 32'd0) begin failures++; $display("FAIL rst_late_rvalid instr=%h data=%h exp %h 0", mem_wb_buff.instr, mem_wb_buff.wb_result, RV_NOP); end
      dmem_bus.dmem_rvalid = 1'b0;
      exec_mem_buff        = mk(32'h07700093, 32'hb0, MEM_NONE, 32'd0, 32'h77);
      #1;
      checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL rst_idle stall=%b req=%b exp 0 0", mem_stall, dmem_bus.dmem_req); end
      cycle();
      idle_inputs();
      checks++; if (mem_wb_buff.wb_result !== 32'h77) begin failures++; $display("FAIL rst_alu got=%h exp=77", mem_wb_buff.wb_result); end
      cycle();
   endtask

   task automatic test_misalign();
      exec_mem_buff = mk(32'h20202083, 32'hc0, LW, 32'h202, 32'd0);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      dmem_bus.dmem_gnt = 1'b1;
      #1;
      checks++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL mis_req req=%b stall=%b exp 0 0", dmem_bus.dmem_req, mem_stall); end
      cycle();
      idle_inputs();
      checks++; if (misalign_fault !== 1'b1 || mem_wb_buff.instr !== RV_NOP) begin failures++; $display("FAIL mis_fault fault=%b instr=%h exp 1 %h", misalign_fault, mem_wb_buff.instr, RV_NOP); end
      cycle();
      checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misalign_fault); end
`else
      dmem_bus.dmem_gnt = 1'b1;
      #1;
      checks++; if (dmem_bus.dmem_addr !== 32'h200 || dmem_bus.dmem_be !== 4'b1111) begin failures++; $display("FAIL mis_align addr=%h be=%b exp 200 1111", dmem_bus.dmem_addr, dmem_bus.dmem_be); end
      cycle();
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'h0102_0304;
      cycle();
      idle_inputs();
      checks++; if (mem_wb_buff.wb_result !== 32'h01020304) begin failures++; $display("FAIL mis_data got=%h exp=01020304", mem_wb_buff.wb_result); end
      cycle();
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_sb();
      test_lb_waits();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
